// File: rtl/shift_pkg.sv
// Shared definitions for the shift datapath: direction codes, deserializer states
// and the shift-control encoding also used by shift_reg's sl/sr pins.
package shift_pkg;

    localparam logic DIR_MSB_FIRST = 1'b1;
    localparam logic DIR_LSB_FIRST = 1'b0;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } deser_state_e;

    // {sr, sl} as driven into shift_reg
    typedef enum logic [1:0] {
        SH_HOLD  = 2'b00,
        SH_LEFT  = 2'b01,
        SH_RIGHT = 2'b10,
        SH_LOAD  = 2'b11
    } shift_op_e;

    function automatic shift_op_e dir_to_op(input logic dir);
        return (dir == DIR_MSB_FIRST) ? SH_LEFT : SH_RIGHT;
    endfunction

endpackage

// File: rtl/deser_obuf.sv
// One-entry valid/ready output buffer for the deserializer, with a sticky flag
// raised when a completed word arrives while the buffered one is still unconsumed.
module deser_obuf #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] p_out,
    output logic              p_valid,
    input  logic              p_ready,
    output logic              ovf
);

    always_ff @(posedge clk) begin
        if (rst) begin
            p_out   <= '0;
            p_valid <= 1'b0;
            ovf     <= 1'b0;
        end else if (load) begin
            // a consumer accepting in the same cycle frees the slot for the new word
            if (!p_valid || p_ready) begin
                p_out   <= din;
                p_valid <= 1'b1;
            end else begin
                ovf <= 1'b1;
            end
        end else if (p_valid && p_ready) begin
            p_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/shift_deser.sv
// Serial-in / parallel-out receiver: assembles DATA_W bits MSB- or LSB-first
// and hands each finished word to a one-entry valid/ready buffer.
module shift_deser
    import shift_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_in,
    input  logic              s_valid,
    input  logic              s_dir,
    input  logic              s_sof,
    output logic [DATA_W-1:0] p_out,
    output logic              p_valid,
    input  logic              p_ready,
    output logic              busy,
    output logic              ovf
);

    localparam int CNT_W = $clog2(DATA_W);

    deser_state_e      state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n, cnt_cur;
    logic [DATA_W-1:0] sh, sh_next;
    logic              dir_q, dir_use, first_bit, done;
    shift_op_e         op;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        first_bit = (state == IDLE) || s_sof;
        dir_use   = first_bit ? s_dir : dir_q;
        op        = dir_to_op(dir_use);
        sh_next   = (op == SH_LEFT) ? {sh[DATA_W-2:0], s_in} : {s_in, sh[DATA_W-1:1]};
        // a start-of-frame bit restarts the count, dropping any partial word
        cnt_cur   = first_bit ? '0 : cnt;
        done      = s_valid && (cnt_cur == CNT_W'(DATA_W - 1));
        if (s_valid) begin
            if (done) begin
                state_n = IDLE;
                cnt_n   = '0;
            end else begin
                state_n = SHIFT;
                cnt_n   = cnt_cur + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sh    <= '0;
            dir_q <= DIR_MSB_FIRST;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            busy  <= (state_n == SHIFT);
            if (s_valid) begin
                sh <= sh_next;
                if (first_bit) dir_q <= s_dir;
            end
        end
    end

    // word boundary: the finished word is registered into the output buffer
    deser_obuf #(
        .DATA_W (DATA_W)
    ) u_obuf (
        .clk     (clk),
        .rst     (rst),
        .load    (done),
        .din     (sh_next),
        .p_out   (p_out),
        .p_valid (p_valid),
        .p_ready (p_ready),
        .ovf     (ovf)
    );

endmodule

// File: tb/tb_shift_deser.sv
// Directed bench for shift_deser (DATA_W=4): a vector table for the basic frames
// plus hand-written sequences for stall, overrun, accept-on-complete and reset.
module tb_shift_deser;

    localparam int DATA_W = 4;

    logic              clk = 1'b0;
    logic              rst, s_in, s_valid, s_dir, s_sof, p_ready;
    logic [DATA_W-1:0] p_out;
    logic              p_valid, busy, ovf;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic              rst;
        logic              v;
        logic              b;
        logic              dir;
        logic              sof;
        logic              rdy;
        logic [DATA_W-1:0] e_out;
        logic              e_pv;
        logic              e_busy;
        logic              e_ovf;
    } vec_t;

    vec_t tbl[$];

    shift_deser #(.DATA_W(DATA_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_in    (s_in),
        .s_valid (s_valid),
        .s_dir   (s_dir),
        .s_sof   (s_sof),
        .p_out   (p_out),
        .p_valid (p_valid),
        .p_ready (p_ready),
        .busy    (busy),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, v, b, d, sof, rdy,
                                input logic [DATA_W-1:0] eo, input logic epv, eb, eov);
        vec_t t;
        t = '{r, v, b, d, sof, rdy, eo, epv, eb, eov};
        return t;
    endfunction

    task automatic step(input vec_t t, input string tag);
        rst     = t.rst;
        s_valid = t.v;
        s_in    = t.b;
        s_dir   = t.dir;
        s_sof   = t.sof;
        p_ready = t.rdy;
        @(posedge clk);
        #1;
        n_vec++;
        if (p_out !== t.e_out || p_valid !== t.e_pv || busy !== t.e_busy || ovf !== t.e_ovf) begin
            n_err++;
            $display("FAIL %s: got p_out=%h p_valid=%b busy=%b ovf=%b, expected p_out=%h p_valid=%b busy=%b ovf=%b",
                     tag, p_out, p_valid, busy, ovf, t.e_out, t.e_pv, t.e_busy, t.e_ovf);
        end
    endtask

    // serial bit helper: rst=0, s_valid=1, s_sof=0
    task automatic bit_in(input logic b, d, rdy, input logic [DATA_W-1:0] eo,
                          input logic epv, eb, eov, input string tag);
        step(mk(1'b0, 1'b1, b, d, 1'b0, rdy, eo, epv, eb, eov), tag);
    endtask

    task automatic idle(input logic rdy, input logic [DATA_W-1:0] eo,
                        input logic epv, eb, eov, input string tag);
        step(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, rdy, eo, epv, eb, eov), tag);
    endtask

    initial begin
        rst = 1'b1; s_in = 1'b0; s_valid = 1'b0; s_dir = 1'b1; s_sof = 1'b0; p_ready = 1'b0;

        //            rst v  b  dir sof rdy  out   pv busy ovf
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 4'h0, 0, 0, 0));   // reset state
        // MSB-first 1,0,1,1
        tbl.push_back(mk(0, 1, 1, 1, 0, 1, 4'h0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 1, 4'h0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 1, 4'h0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 1, 4'hB, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 4'hB, 0, 0, 0));
        // LSB-first 1,0,1,1
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 4'hB, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 1, 4'hB, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 4'hB, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 4'hD, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 4'hD, 0, 0, 0));
        // LSB-first again with s_dir toggled mid-word: still 4'hD
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 4'hD, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 1, 4'hD, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 1, 4'hD, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 4'hD, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 4'hD, 0, 0, 0));
        // resync: 1,1 then sof with 0, then 1,1,0 -> 4'b0110
        tbl.push_back(mk(0, 1, 1, 1, 0, 1, 4'hD, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 1, 4'hD, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 1, 1, 1, 4'hD, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 1, 4'hD, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 1, 0, 1, 4'hD, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 1, 4'h6, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 1, 4'h6, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // stall: 4'hA then 4'h5 with p_ready=0 -> second word dropped, ovf set
        bit_in(1, 1, 0, 4'h6, 0, 1, 0, "stall_a1");
        bit_in(0, 1, 0, 4'h6, 0, 1, 0, "stall_a2");
        bit_in(1, 1, 0, 4'h6, 0, 1, 0, "stall_a3");
        bit_in(0, 1, 0, 4'hA, 1, 0, 0, "stall_a4");
        bit_in(0, 1, 0, 4'hA, 1, 1, 0, "stall_b1");
        bit_in(1, 1, 0, 4'hA, 1, 1, 0, "stall_b2");
        bit_in(0, 1, 0, 4'hA, 1, 1, 0, "stall_b3");
        bit_in(1, 1, 0, 4'hA, 1, 0, 1, "stall_ovf");
        idle(1, 4'hA, 0, 0, 1, "stall_drain");
        idle(1, 4'hA, 0, 0, 1, "ovf_sticky");
        step(mk(1, 0, 0, 1, 0, 0, 4'h0, 0, 0, 0), "rst_clr_ovf");

        // 4'h3 pending, accepted in the cycle 4'hC completes
        bit_in(0, 1, 0, 4'h0, 0, 1, 0, "acc_31");
        bit_in(0, 1, 0, 4'h0, 0, 1, 0, "acc_32");
        bit_in(1, 1, 0, 4'h0, 0, 1, 0, "acc_33");
        bit_in(1, 1, 0, 4'h3, 1, 0, 0, "acc_34");
        bit_in(1, 1, 0, 4'h3, 1, 1, 0, "acc_c1");
        bit_in(1, 1, 0, 4'h3, 1, 1, 0, "acc_c2");
        bit_in(0, 1, 0, 4'h3, 1, 1, 0, "acc_c3");
        bit_in(0, 1, 1, 4'hC, 1, 0, 0, "acc_c4");
        idle(0, 4'hC, 1, 0, 0, "acc_hold");
        step(mk(1, 0, 0, 1, 0, 0, 4'h0, 0, 0, 0), "rst_drop_word");

        // reset mid-word, then 0,1,0,1 with idle gaps (one carrying a stray sof)
        bit_in(1, 1, 1, 4'h0, 0, 1, 0, "rw_pre1");
        bit_in(1, 1, 1, 4'h0, 0, 1, 0, "rw_pre2");
        step(mk(1, 1, 1, 1, 0, 1, 4'h0, 0, 0, 0), "rw_reset");
        bit_in(0, 1, 1, 4'h0, 0, 1, 0, "rw_b1");
        step(mk(0, 0, 1, 1, 1, 1, 4'h0, 0, 1, 0), "rw_gap_sof");
        bit_in(1, 1, 1, 4'h0, 0, 1, 0, "rw_b2");
        idle(1, 4'h0, 0, 1, 0, "rw_gap2");
        bit_in(0, 1, 1, 4'h0, 0, 1, 0, "rw_b3");
        idle(1, 4'h0, 0, 1, 0, "rw_gap3");
        bit_in(1, 1, 1, 4'h5, 1, 0, 0, "rw_b4");
        idle(1, 4'h5, 0, 0, 0, "rw_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/shift_deser.md
Name: shift_deser

Overview:
- Serial-in / parallel-out receiver: the receive end of our parallel-load, left/right shift datapath.
- Collects DATA_W serial bits in either shift direction (MSB-first or LSB-first) and reassembles each word.
- Presents each word on a one-entry valid/ready output buffer.
- Sits between a serial link (or a shift_reg-driven serializer) and word-wide consumer logic.

Parameters:
- DATA_W, 4, word width in bits (>= 2).
- CNT_W, $clog2(DATA_W), bit-counter width (derived localparam, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- s_in  in  1  serial data bit.
- s_valid  in  1  s_in is valid this cycle. No backpressure: every s_valid cycle is consumed.
- s_dir  in  1  1 = MSB-first (shift left, new bit enters at bit 0); 0 = LSB-first (shift right, new bit enters at bit DATA_W-1).
- s_sof  in  1  start of frame; meaningful only with s_valid.
- p_out  out  DATA_W  assembled word.
- p_valid  out  1  p_out holds an unconsumed word.
- p_ready  in  1  consumer accepts p_out when p_valid && p_ready.
- busy  out  1  partial word in progress.
- ovf  out  1  sticky overrun flag.

Behaviour:
- Reset (rst=1 at clk edge) clears:
  - p_out=0, p_valid=0, busy=0, ovf=0;
  - shift register sh=0, counter cnt=0;
  - latched direction dir_q=1;
  - state=IDLE.
- Reset wins over all other inputs. Reset mid-word discards the partial word. Reset while p_valid=1 drops the buffered word.
- States: IDLE (cnt=0, no partial word) and SHIFT (1 <= cnt <= DATA_W-1).
- Bit accept happens on every cycle with s_valid=1:
  - next = s_dir-or-dir_q ? {sh[DATA_W-2:0], s_in} : {s_in, sh[DATA_W-1:1]}.
  - Direction source: s_dir is used when the bit is the first of a word (IDLE, or s_sof=1); dir_q is used otherwise.
  - dir_q <= s_dir on the first bit. s_dir changes mid-word are ignored.
- Counting: first bit sets cnt=1 and moves IDLE->SHIFT. Each further bit increments cnt.
- Word complete: the accepted bit is the DATA_W-th (cnt==DATA_W-1, or DATA_W==... n/a since DATA_W>=2).
  - Completed word = next; cnt->0, state->IDLE.
  - The word appears on p_out with p_valid=1 on the clock edge after the last bit (1-cycle latency).
- s_sof=1 with s_valid=1 in SHIFT: the partial word is discarded silently and this bit becomes bit 1 of a new word (cnt=1). No flag is raised.
- s_sof without s_valid is ignored.
- Output buffer handling on completion:
  - p_valid=0: load the word, p_valid<=1.
  - p_valid=1 and p_ready=1 in the same cycle: load the new word, p_valid stays 1 (back-to-back, no bubble).
  - p_valid=1 and p_ready=0: the new word is dropped, p_out/p_valid are unchanged, and ovf<=1.
- When no word completes: p_valid && p_ready -> p_valid<=0; p_out holds its last value.
- ovf clears only on rst.
- busy = (state==SHIFT), registered.
- Sustained throughput: one word per DATA_W cycles of s_valid.

Decomposition:
- Package shift_pkg holds:
  - DIR_MSB_FIRST=1'b1 and DIR_LSB_FIRST=1'b0;
  - state enum IDLE/SHIFT;
  - a shared shift-direction encoding common with shift_reg's sl/sr control.
- One natural sub-module, deser_obuf: the one-entry valid/ready output buffer with overrun detect (ports clk, rst, load, din, p_out, p_valid, p_ready, ovf).
- The shift/count FSM stays in shift_deser.

Test Plan:
1. MSB-first, DATA_W=4: s_dir=1, bits 1,0,1,1 on consecutive cycles, p_ready=1 -> one cycle after the 4th bit, p_out=4'b1011, p_valid=1 for one cycle; busy=1 during bits 2-4; ovf=0.
2. LSB-first: s_dir=0, bits 1,0,1,1 -> p_out=4'b1101. Toggle s_dir after the first bit -> result unchanged (4'b1101).
3. Back-to-back with stall: two words 4'hA then 4'h5 MSB-first, p_ready=0 throughout -> p_out stays 4'hA, p_valid=1, ovf=1 one cycle after the 8th bit. Then p_ready=1 -> p_valid drops the next cycle; ovf stays 1.
4. Simultaneous accept and complete: p_valid=1 with 4'h3 pending, p_ready=1 in the cycle the last bit of 4'hC arrives -> next cycle p_out=4'hC, p_valid=1, ovf=0.
5. Resync: bits 1,1 then s_sof=1 with bit 0, followed by 1,1,0 (MSB-first) -> p_out=4'b0110; no ovf; the partial 2 bits are discarded.
6. Reset mid-word and gaps: 2 bits in, rst=1 for one cycle, then 4 bits 0,1,0,1 with s_valid idle cycles interleaved -> p_out=4'b0101. After reset, all outputs are 0 until completion.
